// File: rtl/seg7_tick_display_if.sv
// seg7_tick_display_if
//   Signal bundle between the clock-divider side (master) and the
//   seven-segment tick display (slave).
//   master drives : slow_in, scan_in, en, clr (and up_dn with SEG7_DIR_CTRL_EN)
//   slave drives  : an, seg, dp, count, wrap
//   Optional macro: SEG7_DIR_CTRL_EN adds the up_dn direction input.
interface seg7_tick_display_if;
    logic        slow_in;
    logic        scan_in;
    logic        en;
    logic        clr;
`ifdef SEG7_DIR_CTRL_EN
    logic        up_dn;
`endif
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [15:0] count;
    logic        wrap;

    modport master (
        output slow_in, scan_in, en, clr,
`ifdef SEG7_DIR_CTRL_EN
        output up_dn,
`endif
        input  an, seg, dp, count, wrap
    );

    modport slave (
        input  slow_in, scan_in, en, clr,
`ifdef SEG7_DIR_CTRL_EN
        input  up_dn,
`endif
        output an, seg, dp, count, wrap
    );
endinterface

// File: rtl/seg7_tick_display.sv
// seg7_tick_display
//   Counts rising edges of the slow divider clock in a 4-digit BCD counter
//   and time-multiplexes the count onto a 4-digit common-anode display,
//   stepping one digit per rising edge of the scan clock.
//   Ports:
//     clk  - 50 MHz system clock (slow_in/scan_in are sampled on it)
//     ar   - asynchronous reset, active-low
//     bus  - seg7_tick_display_if.slave: slow_in, scan_in, en, clr inputs;
//            an (active-low one-hot), seg {g..a} active-low, dp active-low,
//            count {d3,d2,d1,d0} BCD, wrap (one-cycle pulse) outputs
//   Parameters:
//     BLANK_LZ    - 1 blanks leading zeros on digits 3..1
//     SCAN_DIGITS - number of scanned digits, only 4 is supported
//   Optional macro: SEG7_DIR_CTRL_EN adds up_dn (1 = up, 0 = down count).
module seg7_tick_display #(
    parameter int BLANK_LZ    = 1,
    parameter int SCAN_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  ar,
    seg7_tick_display_if.slave    bus
);
    localparam int IDX_W = 2;

    logic             slow_dly_q, slow_dly_d;
    logic             scan_dly_q, scan_dly_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      count_q, count_d;
    logic             wrap_q, wrap_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic slow_tick, scan_tick;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = 7'b1111111;
        endcase
    endfunction

    assign slow_tick = bus.slow_in & ~slow_dly_q;
    assign scan_tick = bus.scan_in & ~scan_dly_q;

    // Edge-detect delay registers
    always_comb begin
        slow_dly_d = bus.slow_in;
        scan_dly_d = bus.scan_in;
    end

    // BCD counter: ripple the carry (or borrow) digit by digit; a carry
    // out of d3 means the counter wrapped in either direction.
    always_comb begin
        logic       up;
        logic       carry;
        logic [3:0] dig;
        count_d = count_q;
        wrap_d  = 1'b0;
        carry   = 1'b0;
        dig     = 4'd0;
`ifdef SEG7_DIR_CTRL_EN
        up      = bus.up_dn;
`else
        up      = 1'b1;
`endif
        if (bus.clr) begin
            count_d = 16'h0000;
        end else if (bus.en && slow_tick) begin
            carry = 1'b1;
            for (int i = 0; i < 4; i++) begin
                dig = count_q[4*i +: 4];
                if (carry) begin
                    if (up) begin
                        if (dig == 4'd9) dig = 4'd0;
                        else begin dig = dig + 4'd1; carry = 1'b0; end
                    end else begin
                        if (dig == 4'd0) dig = 4'd9;
                        else begin dig = dig - 4'd1; carry = 1'b0; end
                    end
                end
                count_d[4*i +: 4] = dig;
            end
            wrap_d = carry;
        end
    end

    // Scan index, free-running on scan ticks
    always_comb begin
        idx_d = idx_q;
        if (scan_tick)
            idx_d = (idx_q == IDX_W'(SCAN_DIGITS - 1)) ? '0 : idx_q + 2'd1;
    end

    // Display decode from the current index and count (registered below)
    always_comb begin
        logic [3:0] sel;
        logic       blank;
        sel   = count_q[{idx_q, 2'b00} +: 4];
        blank = 1'b0;
        case (idx_q)
            2'd3:    blank = (count_q[15:12] == 4'h0);
            2'd2:    blank = (count_q[15:8]  == 8'h00);
            2'd1:    blank = (count_q[15:4]  == 12'h000);
            default: blank = 1'b0;
        endcase
        an_d  = ~(4'b0001 << idx_q);
        seg_d = (blank && (BLANK_LZ != 0)) ? 7'b1111111 : seg_code(sel);
        // Heartbeat: dp on digit 0 follows the slow clock
        dp_d  = ~((idx_q == 2'd0) & bus.slow_in);
    end

    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            slow_dly_q <= 1'b0;
            scan_dly_q <= 1'b0;
            idx_q      <= '0;
            count_q    <= 16'h0000;
            wrap_q     <= 1'b0;
            an_q       <= 4'b1111;
            seg_q      <= 7'b1111111;
            dp_q       <= 1'b1;
        end else begin
            slow_dly_q <= slow_dly_d;
            scan_dly_q <= scan_dly_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign bus.an    = an_q;
    assign bus.seg   = seg_q;
    assign bus.dp    = dp_q;
    assign bus.count = count_q;
    assign bus.wrap  = wrap_q;
endmodule

// File: tb/tb_seg7_tick_display.sv
// tb_seg7_tick_display
//   Directed, table-driven bench for seg7_tick_display plus hand-written
//   sequences for tick latency, held-high input, clear priority, wrap,
//   reset mid-operation and (with SEG7_DIR_CTRL_EN) down counting.
module tb_seg7_tick_display;
    logic clk = 1'b0;
    logic ar  = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    seg7_tick_display_if bus_if ();

    seg7_tick_display #(.BLANK_LZ(1), .SCAN_DIGITS(4)) dut (
        .clk (clk),
        .ar  (ar),
        .bus (bus_if)
    );

    always #10 clk = ~clk;

    typedef struct {
        int          n_slow;
        int          n_scan;
        bit          en;
        logic [15:0] exp_count;
        logic [3:0]  exp_an;
        logic [6:0]  exp_seg;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick_slow();
        @(posedge clk); #1 bus_if.slow_in = 1'b1;
        @(posedge clk); #1 bus_if.slow_in = 1'b0;
    endtask

    task automatic tick_scan();
        @(posedge clk); #1 bus_if.scan_in = 1'b1;
        @(posedge clk); #1 bus_if.scan_in = 1'b0;
    endtask

    // Let the index/count reach the registered display outputs
    task automatic settle();
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_clr();
        @(posedge clk); #1 bus_if.clr = 1'b1;
        @(posedge clk); #1 bus_if.clr = 1'b0;
    endtask

    initial begin
        //           slow scan en count     an       seg
        vecs[0]  = '{12, 0, 1'b1, 16'h0012, 4'b1110, 7'b0100100};
        vecs[1]  = '{ 0, 1, 1'b1, 16'h0012, 4'b1101, 7'b1111001};
        vecs[2]  = '{ 0, 1, 1'b1, 16'h0012, 4'b1011, 7'b1111111};
        vecs[3]  = '{ 0, 1, 1'b1, 16'h0012, 4'b0111, 7'b1111111};
        vecs[4]  = '{ 0, 1, 1'b1, 16'h0012, 4'b1110, 7'b0100100};
        vecs[5]  = '{ 5, 0, 1'b0, 16'h0012, 4'b1110, 7'b0100100};
        vecs[6]  = '{29, 0, 1'b1, 16'h0041, 4'b1110, 7'b1111001};
        vecs[7]  = '{59, 0, 1'b1, 16'h0100, 4'b1110, 7'b1000000};
        vecs[8]  = '{ 0, 2, 1'b1, 16'h0100, 4'b1011, 7'b1111001};
        vecs[9]  = '{ 0, 1, 1'b1, 16'h0100, 4'b0111, 7'b1111111};
        vecs[10] = '{ 0, 3, 1'b1, 16'h0100, 4'b1011, 7'b1111001};
        vecs[11] = '{ 0, 3, 1'b1, 16'h0100, 4'b1101, 7'b1000000};
        vecs[12] = '{ 0, 3, 1'b1, 16'h0100, 4'b1110, 7'b1000000};

        bus_if.slow_in = 1'b0;
        bus_if.scan_in = 1'b0;
        bus_if.en      = 1'b0;
        bus_if.clr     = 1'b0;
`ifdef SEG7_DIR_CTRL_EN
        bus_if.up_dn   = 1'b1;
`endif

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_count", bus_if.count, 16'h0000);
        chk("rst_an",    bus_if.an,    4'b1111);
        chk("rst_seg",   bus_if.seg,   7'b1111111);
        chk("rst_dp",    bus_if.dp,    1'b1);
        chk("rst_wrap",  bus_if.wrap,  1'b0);

        @(posedge clk); #1 ar = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("first_an",  bus_if.an,  4'b1110);
        chk("first_seg", bus_if.seg, 7'b1000000);

        // Table-driven count/scan vectors
        for (int v = 0; v < 13; v++) begin
            bus_if.en = vecs[v].en;
            for (int s = 0; s < vecs[v].n_slow; s++) tick_slow();
            for (int s = 0; s < vecs[v].n_scan; s++) tick_scan();
            settle();
            chk($sformatf("vec%0d_count", v), bus_if.count, vecs[v].exp_count);
            chk($sformatf("vec%0d_an", v),    bus_if.an,    vecs[v].exp_an);
            chk($sformatf("vec%0d_seg", v),   bus_if.seg,   vecs[v].exp_seg);
            chk($sformatf("vec%0d_wrap", v),  bus_if.wrap,  1'b0);
        end

        // Tick latency, held-high slow_in, dp heartbeat (index is 0 here)
        bus_if.en = 1'b1;
        @(posedge clk); #1 bus_if.slow_in = 1'b1;
        @(negedge clk);
        chk("lat_tick_cycle", bus_if.count, 16'h0100);
        chk("lat_dp_before",  bus_if.dp,    1'b1);
        @(negedge clk);
        chk("lat_next_cycle", bus_if.count, 16'h0101);
        chk("dp_heartbeat",   bus_if.dp,    1'b0);
        repeat (5) @(negedge clk);
        chk("held_high",      bus_if.count, 16'h0101);
        #1 bus_if.slow_in = 1'b0;
        settle();
        chk("dp_off",         bus_if.dp,    1'b1);

        // Clear wins over a same-cycle tick with count 0041
        do_clr();
        for (int s = 0; s < 41; s++) tick_slow();
        @(negedge clk);
        chk("pre_clr_count", bus_if.count, 16'h0041);
        @(posedge clk); #1 begin bus_if.slow_in = 1'b1; bus_if.clr = 1'b1; end
        @(posedge clk); #1 begin bus_if.slow_in = 1'b0; bus_if.clr = 1'b0; end
        @(negedge clk);
        chk("clr_tick_count", bus_if.count, 16'h0000);
        chk("clr_tick_wrap",  bus_if.wrap,  1'b0);

        // Wrap 9999 -> 0000
        for (int s = 0; s < 9999; s++) tick_slow();
        @(negedge clk);
        chk("pre_wrap_count", bus_if.count, 16'h9999);
        chk("pre_wrap_wrap",  bus_if.wrap,  1'b0);
        tick_slow();
        @(negedge clk);
        chk("wrap_count", bus_if.count, 16'h0000);
        chk("wrap_pulse", bus_if.wrap,  1'b1);
        @(negedge clk);
        chk("wrap_clear", bus_if.wrap,  1'b0);

`ifdef SEG7_DIR_CTRL_EN
        bus_if.up_dn = 1'b0;
        tick_slow();
        @(negedge clk);
        chk("dn_count", bus_if.count, 16'h9999);
        chk("dn_wrap",  bus_if.wrap,  1'b1);
        @(negedge clk);
        chk("dn_wrap_clear", bus_if.wrap, 1'b0);
        bus_if.up_dn = 1'b1;
        tick_slow();
        @(negedge clk);
        chk("up_again_count", bus_if.count, 16'h0000);
`endif

        // Reset mid-operation with count 0123
        do_clr();
        for (int s = 0; s < 123; s++) tick_slow();
        tick_scan();
        tick_scan();
        @(negedge clk);
        chk("pre_rst_count", bus_if.count, 16'h0123);
        ar = 1'b0;
        #1;
        chk("mid_rst_count", bus_if.count, 16'h0000);
        chk("mid_rst_an",    bus_if.an,    4'b1111);
        chk("mid_rst_seg",   bus_if.seg,   7'b1111111);
        chk("mid_rst_wrap",  bus_if.wrap,  1'b0);
        @(posedge clk); #1 ar = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("post_rst_an",  bus_if.an,  4'b1110);
        chk("post_rst_seg", bus_if.seg, 7'b1000000);
        for (int k = 1; k < 4; k++) begin
            logic [3:0] exp_an;
            exp_an = ~(4'b0001 << k);
            tick_scan();
            settle();
            chk($sformatf("post_rst_an%0d", k),  bus_if.an,  exp_an);
            chk($sformatf("post_rst_blank%0d", k), bus_if.seg, 7'b1111111);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg7_tick_display.md
Name: seg7_tick_display

Overview:
- Downstream consumer of the clock divider's two output clocks. Both inputs are generated in the same 50 MHz domain and are sampled on clk.
- Counts rising edges of the slow 2 s clock in a 4-digit BCD counter.
- Time-multiplexes the count onto a 4-digit common-anode seven-segment display, advancing one digit per rising edge of the 1 kHz scan clock.

Parameters:
- BLANK_LZ, 1, 1 = blank leading zeros on digits 3..1; 0 = show all digits.
- SCAN_DIGITS, 4, number of scanned digits. Fixed at 4; any other value is unsupported.

Ports:
- clk  input  1  system clock, 50 MHz
- ar  input  1  asynchronous reset, active-low
- slow_in  input  1  2 s period clock from the divider (x)
- scan_in  input  1  1 kHz clock from the divider (y)
- en  input  1  count enable, level-sensitive, active-high
- clr  input  1  synchronous count clear, active-high
- an  output  4  digit anodes, active-low one-hot
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low
- count  output  16  current BCD count {d3,d2,d1,d0}
- wrap  output  1  one-cycle pulse on counter wrap

Behaviour:
- Reset is asynchronous and active-low on ar; single clock clk.
- Reset values: count=16'h0000, digit index=0, an=4'b1111, seg=7'b1111111, dp=1, wrap=0, both edge-detect registers=0.
- Edge detect:
  - slow_d <= slow_in and scan_d <= scan_in every cycle.
  - slow_tick = slow_in & ~slow_d; scan_tick = scan_in & ~scan_d.
  - A tick is exactly one clk cycle wide.
- Counter:
  - Priority order: clr, then (en & slow_tick).
  - clr=1: count <= 0 and wrap <= 0, regardless of any tick in the same cycle.
  - en & slow_tick: BCD increment. d0 rolls 9 to 0 and carries into d1, and so on up the digits.
  - 9999 to 0000 wraps and asserts wrap=1 for exactly that next cycle; wrap is 0 otherwise.
  - Count update is visible one cycle after the tick cycle.
  - BCD digits never take values A..F.
- Scanner:
  - On scan_tick, index <= index+1 mod 4 (3 wraps to 0).
  - Scanning is independent of en and clr.
- Display outputs:
  - an, seg and dp are registered and recomputed every cycle from the current index and count, so each has one cycle of latency.
  - an: index 0 gives 1110, 1 gives 1101, 2 gives 1011, 3 gives 0111.
  - Digit 0 = least significant digit.
- Segment codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Leading-zero blanking (BLANK_LZ=1):
  - Digit k (k=3..1) shows seg=1111111 if it and every higher digit are 0.
  - Digit 0 is never blanked.
- dp: 0 while index==0 and slow_in==1 (heartbeat); 1 otherwise.
- Reset mid-operation: all state returns to reset values immediately. The first display frame after release shows digit 0.

Optional Feature:
- Macro: SEG7_DIR_CTRL_EN.
- Defined:
  - Adds input port up_dn (1 bit); 1 = count up, 0 = count down.
  - Down-count is a BCD decrement; 0000 wraps to 9999 and pulses wrap.
  - clr priority and latency are unchanged.
  - up_dn is sampled in the tick cycle.
- Undefined: no up_dn port; up-count only.

Test Plan:
- Assert ar=0 mid-scan with count=0123 -> immediately count=0000, an=1111, seg=1111111, wrap=0. After release, first frame shows digit 0 as seg=1000000 and digits 3..1 blanked.
- en=1, 12 rising edges on slow_in -> count=16'h0012. Exactly one update per edge, each one cycle after the tick; a held-high slow_in gives no extra count.
- Preload to 9999 via 9999 ticks (or force), one more tick -> count=0000, wrap=1 for one cycle then 0.
- en=0, 5 slow edges -> count unchanged. Scanning still cycles an 1110, 1101, 1011, 0111, 1110 on successive scan_in edges.
- clr=1 in the same cycle as slow_tick with count=0041 -> count=0000, no increment, wrap=0.
- SEG7_DIR_CTRL_EN defined, up_dn=0, count=0000, one tick -> count=9999, wrap pulses. With up_dn=1 and one more tick -> count=0000.
